// File: rtl/microproc_pkg.sv
// Shared definitions for the instruction sequencer slice.
// Optional STATUS_FLAGS_EN adds the zero/carry flag outputs.
package microproc_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LI  = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_OUT = 2'b11;

   // instruction field bit positions
   localparam int OPC_HI = 7;
   localparam int OPC_LO = 6;
   localparam int RS_HI  = 5;
   localparam int RS_LO  = 4;
   localparam int RT_HI  = 3;
   localparam int RT_LO  = 2;
   localparam int RD_HI  = 1;
   localparam int RD_LO  = 0;
   localparam int IMM_HI = 3;
   localparam int IMM_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB,
      S_OUT
   } state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: ADD, LI (sign-extended imm), SUB, OUT pass-through.
// With STATUS_FLAGS_EN it also reports carry (ADD) or borrow (SUB).
module seq_alu
   import microproc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_opa,
   input  logic [DATA_W-1:0] i_opb,
   input  logic [3:0]        i_imm,
`ifdef STATUS_FLAGS_EN
   output logic              o_carry,
`endif
   output logic [DATA_W-1:0] o_result
);

`ifdef STATUS_FLAGS_EN
   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;

   assign w_sum   = {1'b0, i_opa} + {1'b0, i_opb};
   assign w_diff  = {1'b0, i_opa} - {1'b0, i_opb};
   assign o_carry = (i_op == OP_SUB) ? w_diff[DATA_W] : w_sum[DATA_W];
`else
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;

   assign w_sum  = i_opa + i_opb;
   assign w_diff = i_opa - i_opb;
`endif

   logic [DATA_W-1:0] w_imm;

   assign w_imm = {{(DATA_W-4){i_imm[3]}}, i_imm};

   always_comb begin
      o_result = i_opa;
      unique case (i_op)
         OP_ADD: o_result = w_sum[DATA_W-1:0];
         OP_LI:  o_result = w_imm;
         OP_SUB: o_result = w_diff[DATA_W-1:0];
         OP_OUT: o_result = i_opa;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state-per-instruction issue/execute controller in front of the 4x8 register file.
// Define STATUS_FLAGS_EN to add registered flag_z / flag_c outputs.
module instr_sequencer
   import microproc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef STATUS_FLAGS_EN
   output logic              flag_z,
   output logic              flag_c,
`endif
   output logic              busy
);

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_ir;
   logic [DATA_W-1:0] r_opa;
   logic [DATA_W-1:0] r_opb;
   logic [DATA_W-1:0] r_res;
   logic [ADDR_W-1:0] r_wreg;
   logic [ADDR_W-1:0] r_rd1;
   logic [ADDR_W-1:0] r_rd2;
   logic [DATA_W-1:0] w_alu;
   logic [1:0]        w_op;

   assign w_op = r_ir[OPC_HI:OPC_LO];

`ifdef STATUS_FLAGS_EN
   logic w_carry;
   logic r_z;
   logic r_c;

   assign flag_z = r_z;
   assign flag_c = r_c;
`endif

   seq_alu #(.DATA_W(DATA_W)) u_alu (
      .i_op     (w_op),
      .i_opa    (r_opa),
      .i_opb    (r_opb),
      .i_imm    (r_ir[IMM_HI:IMM_LO]),
`ifdef STATUS_FLAGS_EN
      .o_carry  (w_carry),
`endif
      .o_result (w_alu)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      rf_write    = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) w_next = S_READ;
         end
         S_READ: w_next = S_EXEC;
         S_EXEC: w_next = (w_op == OP_OUT) ? S_OUT : S_WB;
         S_WB: begin
            rf_write = 1'b1;
            w_next   = S_IDLE;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Read addresses load at accept so they are settled for READ and hold afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir  <= '0;
         r_rd1 <= '0;
         r_rd2 <= '0;
         r_opa <= '0;
         r_opb <= '0;
         r_res <= '0;
         r_wreg <= '0;
`ifdef STATUS_FLAGS_EN
         r_z <= 1'b0;
         r_c <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE && instr_valid) begin
            r_ir  <= instr;
            r_rd1 <= ADDR_W'(instr[RS_HI:RS_LO]);
            r_rd2 <= ADDR_W'(instr[RT_HI:RT_LO]);
         end
         if (r_state == S_READ) begin
            r_opa <= rf_read_data1;
            r_opb <= rf_read_data2;
         end
         if (r_state == S_EXEC) begin
            r_res  <= w_alu;
            r_wreg <= (w_op == OP_LI) ? ADDR_W'(r_ir[RS_HI:RS_LO])
                                      : ADDR_W'(r_ir[RD_HI:RD_LO]);
`ifdef STATUS_FLAGS_EN
            if (w_op == OP_ADD || w_op == OP_SUB) begin
               r_z <= (w_alu == '0);
               r_c <= w_carry;
            end
`endif
         end
      end
   end

   assign rf_read_reg1  = r_rd1;
   assign rf_read_reg2  = r_rd2;
   assign rf_write_reg  = r_wreg;
   assign rf_write_data = r_res;
   assign out_data      = r_res;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle issue/execute controller sitting directly upstream of the 4x8-bit register file.
- Accepts 8-bit instructions over a valid/ready handshake, decodes them, drives the register-file read ports, and computes the ALU result.
- Drives the register-file write port with one write-enable pulse, or presents a register value on an output stream.
- Single-issue, in-order, one instruction in flight.

Parameters:
- DATA_W, 8, datapath width; must match register-file data width.
- ADDR_W, 2, register index width (4 registers).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- instr  in  8  instruction: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd
- instr_valid  in  1  instr is valid
- instr_ready  out  1  sequencer can accept an instruction
- rf_read_reg1  out  ADDR_W  register-file read address 1 (rs)
- rf_read_reg2  out  ADDR_W  register-file read address 2 (rt)
- rf_read_data1  in  DATA_W  register-file read data 1 (combinational)
- rf_read_data2  in  DATA_W  register-file read data 2 (combinational)
- rf_write  out  1  register-file write enable
- rf_write_reg  out  ADDR_W  register-file write address
- rf_write_data  out  DATA_W  register-file write data
- out_data  out  DATA_W  OUT instruction result
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- ISA:
  - 00 ADD: rd <= rs + rt.
  - 01 LI: instr[5:4] <= sign-extend(instr[3:0]) to DATA_W.
  - 10 SUB: rd <= rs - rt.
  - 11 OUT: emit rs on the output stream.
- Arithmetic is modulo 2^DATA_W; carry/borrow is discarded unless STATUS_FLAGS_EN is defined.
- States: IDLE, READ, EXEC, WB, OUT.
- IDLE:
  - instr_ready = 1.
  - On instr_valid: latch instr into ir, go to READ.
  - instr_ready is low in every other state.
- READ:
  - rf_read_reg1 = ir[5:4], rf_read_reg2 = ir[3:2].
  - Latch rf_read_data1/2 into opA/opB at the clock edge, go to EXEC.
- EXEC:
  - Compute result, register it into res; register write address (rd, or ir[5:4] for LI).
  - Go to WB for opcodes 00/01/10, OUT for 11.
- WB:
  - rf_write = 1 for exactly one full cycle, with rf_write_reg/rf_write_data stable for the whole cycle. The register file captures during the low phase.
  - Go to IDLE.
- OUT:
  - out_valid = 1, out_data = opA held stable.
  - On out_ready: go to IDLE. Stall indefinitely otherwise.
- Latency/throughput:
  - Instruction accepted at edge N: write pulse asserted during cycle N+3; next accept no earlier than edge N+4 (one instruction per 4 cycles).
  - OUT: out_valid first high in cycle N+3.
- Back-to-back dependency (write then read same register): no hazard. WB completes before the next READ.
- rf_read_reg1/2 hold their last driven values outside READ (no glitching to 0).
- Reset (asynchronous, any state, including mid-WB or mid-OUT stall):
  - state = IDLE; rf_write = 0; out_valid = 0.
  - ir, opA, opB, res, out_data, rf_write_data, rf_write_reg, rf_read_reg1/2 = 0.
  - instr_ready = 1 immediately after reset deasserts; busy = 0.
  - An in-flight instruction is dropped with no write.

Optional Feature:
- Macro STATUS_FLAGS_EN.
- Defined:
  - Adds outputs flag_z (1 bit) and flag_c (1 bit), both registered and updated in EXEC for ADD/SUB only.
  - flag_z = (result == 0).
  - flag_c = carry-out for ADD, borrow for SUB (opA < opB).
  - LI and OUT leave flags unchanged.
  - Both flags reset to 0.
- Not defined: ports absent, no flag logic.

Decomposition:
- Shared package (microproc_pkg):
  - Opcode constants OP_ADD=2'b00, OP_LI=2'b01, OP_SUB=2'b10, OP_OUT=2'b11.
  - State enum (IDLE, READ, EXEC, WB, OUT).
  - Instruction field bit positions.
  - DATA_W/ADDR_W defaults.
- One sub-module: seq_alu, combinational (opcode, opA, opB, imm) -> result, plus carry when STATUS_FLAGS_EN.
- FSM and registers stay in instr_sequencer.

Test Plan:
- Reset, then LI r1,#5 (8'b01_01_0101) -> rf_write high one cycle, 3 cycles after accept; rf_write_reg=1, rf_write_data=8'h05.
- LI r2,#-3 (8'b01_10_1101) -> rf_write_data=8'hFD (sign extension).
- ADD r3=r1+r2 with r1=8'hFF, r2=8'h02 -> rf_write_data=8'h01, rf_write_reg=3; with STATUS_FLAGS_EN: flag_c=1, flag_z=0.
- SUB r0=r1-r1 with r1=8'h07 -> rf_write_data=8'h00; flags z=1, c=0. Next instruction reads r0=0 with no hazard.
- OUT r1 with out_ready held low 5 cycles -> out_valid stays high, out_data stable at r1 value, instr_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- instr_valid held high continuously across 3 instructions -> accepts exactly every 4 cycles. Reset asserted during WB -> rf_write drops immediately, state IDLE, no further writes.
